// File: rtl/seq_load_ctrl.sv
// Byte-stream loader: ASCII -> 4-bit nucleotide codes packed into buffer words.
// Define REV_COMP_EN to honour the revcomp port (reverse-complement loads).
module seq_load_ctrl #(
  parameter  int NT_PER_WORD = 8,
  parameter  int ADDR_W      = 10,
  parameter  int LEN_W       = 16,
  localparam int WORD_W      = 4 * NT_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              revcomp,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_ascii,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  n_count
);

  localparam int LW = $clog2(NT_PER_WORD);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  pos_q, pos_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        raw;
  logic [3:0]        code;
  logic [LW-1:0]     lane;
  logic [WORD_W-1:0] pack_nx;
  logic              last;
  logic              full;
  logic              accept;

  function automatic logic [3:0] nt_map(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: nt_map = 4'd1;
      8'h43, 8'h63: nt_map = 4'd2;
      8'h47, 8'h67: nt_map = 4'd3;
      8'h54, 8'h74: nt_map = 4'd4;
      default:      nt_map = 4'd0;
    endcase
  endfunction

`ifdef REV_COMP_EN
  logic rev_q, rev_d;

  // A<->T and C<->G are symmetric around 5 in the code map.
  function automatic logic [3:0] nt_comp(input logic [3:0] c);
    nt_comp = (c == 4'd0) ? 4'd0 : 4'd5 - c;
  endfunction

  assign code = rev_q ? nt_comp(raw) : raw;
  assign full = rev_q ? (lane == '0)
                      : (lane == LW'(NT_PER_WORD - 1));
`else
  logic rev_unused;
  assign rev_unused = revcomp;
  assign code = raw;
  assign full = (lane == LW'(NT_PER_WORD - 1));
`endif

  assign in_ready = (state_q == LOAD);
  assign accept   = in_ready && in_valid;
  assign raw      = nt_map(in_ascii);
  assign lane     = pos_q[LW-1:0];
  assign last     = (rem_q == LEN_W'(1));
  assign pack_nx  = pack_q | (WORD_W'(code) << (4 * lane));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    n_d     = n_q;
    base_d  = base_q;
    addr_d  = addr_q;
    pack_d  = pack_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef REV_COMP_EN
    rev_d   = rev_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (seq_len != '0) begin
            state_d = LOAD;
            rem_d   = seq_len;
            base_d  = base_addr;
            pack_d  = '0;
            n_d     = '0;
            pos_d   = '0;
`ifdef REV_COMP_EN
            rev_d   = revcomp;
            if (revcomp) pos_d = seq_len - LEN_W'(1);
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          pos_d = pos_q + LEN_W'(1);
`ifdef REV_COMP_EN
          if (rev_q) pos_d = pos_q - LEN_W'(1);
`endif
          if (raw == 4'd0) n_d = n_q + LEN_W'(1);
          if (full || last) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(pos_q >> LW);
            data_d = pack_nx;
            pack_d = '0;
          end else begin
            pack_d = pack_nx;
          end
          if (last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      pos_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REV_COMP_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      n_q     <= n_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REV_COMP_EN
      rev_q   <= rev_d;
`endif
    end
  end

  assign wr_en   = we_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign n_count = n_q;

endmodule

// File: doc/seq_load_ctrl.md
# seq_load_ctrl

Loader controller that sequences the ASCII-to-nucleotide conversion for one sequence at a time. It accepts a byte stream of ASCII characters over a valid/ready handshake and converts each character to a 4-bit nucleotide code. It packs the codes into words and issues single-cycle writes to a sequence buffer, in forward or reverse-complement order. It sits between the host/DMA byte stream and the reference/query sequence RAMs feeding the alignment array.

## Interface
- NT_PER_WORD, 8, nucleotides packed per buffer word; WORD_W = 4*NT_PER_WORD.
- ADDR_W, 10, sequence-buffer word-address width.
- LEN_W, 16, width of the sequence-length field, in characters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load; ignored while busy.
- seq_len  in  LEN_W  number of characters to load; sampled with start.
- revcomp  in  1  1 = reverse-complement load; sampled with start.
- base_addr  in  ADDR_W  first buffer word address; sampled with start.
- in_ascii  in  8  input character.
- in_valid  in  1  in_ascii valid.
- in_ready  out  1  controller accepts a character this cycle.
- wr_en  out  1  buffer write strobe, one cycle per word.
- wr_addr  out  ADDR_W  buffer word address.
- wr_data  out  WORD_W  packed codes; lane k = bits 4k+3:4k.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at the end of a load.
- n_count  out  LEN_W  characters in the current/last load that map to N.

## Operation
- Code map (case-insensitive): A/a=1, C/c=2, G/g=3, T/t=4, anything else=0 (N). Complement maps A<->T and C<->G; N stays N.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE, start=1, seq_len!=0: latch len, revcomp, base_addr; clear char counter, packing register and n_count; go to LOAD.
  - IDLE, start=1, seq_len==0: go directly to DONE. No writes.
  - LOAD: in_ready=1. A character is accepted when in_valid&&in_ready.
  - Character index i runs 0..len-1.
  - Forward: position p=i, code=map(char).
  - Revcomp: position p=len-1-i, code=complement(map(char)).
  - Code goes to lane p%NT_PER_WORD of the word at base_addr + p/NT_PER_WORD.
  - A word is written when the accepted character fills its last lane in stream order (forward: lane NT_PER_WORD-1; revcomp: lane 0), or when it is the final character.
  - Lanes not written in a partial word are 0.
  - When the final character is accepted, go to FLUSH. In FLUSH, in_ready=0.
  - FLUSH: one cycle; the final wr_en is issued, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- n_count increments once per accepted character whose map is 0. It is held after done until the next start.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, n_count=0, FSM=IDLE.
- All outputs are registered except in_ready, which decodes the FSM state only.
- start at cycle t: busy=1 and in_ready=1 from t+1.
- A character that completes a word, accepted at cycle c, produces wr_en at c+1 with that word's address and data.
- Final character accepted at cycle c: wr_en at c+1 (FLUSH), done at c+2, busy falls at c+3.
- seq_len=0: start at t gives done at t+1 and busy=1 only during t+1.
- in_valid gaps stall the controller with no side effects. in_ascii is ignored when in_valid=0.
- start during busy is ignored; seq_len, revcomp and base_addr are not resampled.
- rst_n asserted mid-load: immediate return to reset values; the partial word is discarded.

## Configuration
- REV_COMP_EN defined: revcomp is honoured as described above.
- REV_COMP_EN undefined: the revcomp port is present but ignored. All loads are forward; complement and reverse-position logic are not synthesized.

## Test plan
- Forward "ACGTACGT", len 8, base 0 -> single write addr 0x000, data 0x43214321; done 2 cycles after the 8th accept; n_count=0.
- Revcomp "AACG", len 4, base 0x010 (REV_COMP_EN) -> single write addr 0x010, data 0x00004432.
- Forward "ACGTNacgtx", len 10, base 0x3FF -> writes addr 0x3FF data 0x32104321, then addr 0x000 (wrap) data 0x00000004; n_count=2.
- Same stimulus as the first case with in_valid low every other cycle -> identical writes; in_ready stays high in LOAD; no extra wr_en.
- start with len 0 -> done at t+1, no wr_en. Second start pulse during a load -> ignored; outputs match the single-load case.
- rst_n low mid-LOAD after 5 chars -> all outputs return to reset values immediately. A fresh start then loads correctly, with n_count restarting from 0.
